// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// One op per accepted start; XLEN iterations of shift-add (mul) or
// restoring shift-subtract (div), then a one-cycle done pulse with a
// registered result. Divide-by-zero and signed overflow finish in one cycle.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a combinational
// multiplier and finish in one cycle; divides stay iterative.
module ex_muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            flush,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN-1);

   state_e              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;   // |a| for multiply, |b| (divisor) for divide
   logic [2*XLEN-1:0]   acc_q, acc_d;     // mul: {partial, multiplier}; div: {rem, quotient}
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                neg_q, neg_d;     // final result must be negated
   logic [XLEN-1:0]     res_q, res_d;

   // Operand sign handling at the issue cycle
   logic            a_neg, b_neg, ovf;
   logic [XLEN-1:0] abs_a, abs_b;

   always_comb begin
      a_neg = ((op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM)) && src_a[XLEN-1];
      b_neg = ((op == OP_MUL) || (op == OP_MULH) ||
               (op == OP_DIV) || (op == OP_REM)) && src_b[XLEN-1];
      abs_a = a_neg ? -src_a : src_a;
      abs_b = b_neg ? -src_b : src_b;
      ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
              (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
   end

`ifdef MULDIV_FAST_MUL_EN
   // Sign-extended full-width product; truncation to 2*XLEN is exact
   logic [2*XLEN-1:0] fm_a, fm_b, fm_p;
   always_comb begin
      fm_a = {{XLEN{a_neg}}, src_a};
      fm_b = {{XLEN{b_neg}}, src_b};
      fm_p = fm_a * fm_b;
   end
`endif

   // One iteration of the datapath plus the final sign fixup
   logic [XLEN:0]     mul_sum, div_sh, div_diff;
   logic              div_ok;
   logic [2*XLEN-1:0] step_nxt, prod_fx;
   logic [XLEN-1:0]   qr_sel, qr_fx, fin_res;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_sh   = acc_q[2*XLEN-1:XLEN-1];
      div_diff = div_sh - {1'b0, opnd_q};
      div_ok   = !div_diff[XLEN];
      if (op_q[2])
         step_nxt = {(div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ok};
      else
         step_nxt = {mul_sum, acc_q[XLEN-1:1]};
      prod_fx = neg_q ? -step_nxt : step_nxt;
      qr_sel  = op_q[1] ? step_nxt[2*XLEN-1:XLEN] : step_nxt[XLEN-1:0];
      qr_fx   = neg_q ? -qr_sel : qr_sel;
      if (op_q[2])
         fin_res = qr_fx;
      else if (op_q == OP_MUL)
         fin_res = prod_fx[XLEN-1:0];
      else
         fin_res = prod_fx[2*XLEN-1:XLEN];
   end

   // Next-state and datapath update; flush overrides everything
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      res_d   = res_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !flush) begin
               op_d  = op;
               cnt_d = '0;
               if (op[2] && (src_b == '0)) begin
                  res_d   = op[1] ? src_a : '1;
                  state_d = S_DONE;
               end else if (ovf) begin
                  res_d   = op[1] ? '0 : src_a;
                  state_d = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
               end else if (!op[2]) begin
                  res_d   = (op == OP_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
                  state_d = S_DONE;
`endif
               end else begin
                  state_d = S_CALC;
                  if (op[2]) begin
                     opnd_d = abs_b;
                     acc_d  = {{XLEN{1'b0}}, abs_a};
                     neg_d  = op[1] ? a_neg : (a_neg ^ b_neg);
                  end else begin
                     opnd_d = abs_a;
                     acc_d  = {{XLEN{1'b0}}, abs_b};
                     neg_d  = a_neg ^ b_neg;
                  end
               end
            end
         end
         S_CALC: begin
            acc_d = step_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               res_d   = fin_res;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
         res_d   = res_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
      end
   end

   assign stall  = ((state_q == S_IDLE) && start && !flush) || (state_q == S_CALC);
   assign done   = (state_q == S_DONE) && !flush;
   assign result = res_q;

endmodule
